// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD controller.
// Register field positions, FSM states and the power-up init ROM.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_EXEC,
    S_IDLE
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  localparam int LCD_DATA_LSB = 0;
  localparam int LCD_RS_BIT   = 8;
  localparam int LCD_ON_BIT   = 31;

  localparam logic [7:0] INIT_ROM0 = 8'h38;
  localparam logic [7:0] INIT_ROM1 = 8'h0C;
  localparam logic [7:0] INIT_ROM2 = 8'h01;
  localparam logic [7:0] INIT_ROM3 = 8'h06;

  function automatic logic [7:0] init_rom(
    input logic [1:0] idx
  );
    logic [7:0] v;
    unique case (idx)
      2'd0:    v = INIT_ROM0;
      2'd1:    v = INIT_ROM1;
      2'd2:    v = INIT_ROM2;
      default: v = INIT_ROM3;
    endcase
    return v;
  endfunction

  // clear display / return home need the long execution wait
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data == 8'h01 ||
                   data == 8'h02 ||
                   data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Down-counter used for every timed FSM phase.
// Saturates at zero; o_done while the count is zero.
module lcd_timer #(
  parameter int W       = 8,
  parameter int RST_VAL = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= W'(RST_VAL);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 bus-cycle generator fed by the LSU LCD register.
// Power-up init, one-entry pending slot, busy/overrun status.
module lcd_hd44780_ctrl #(
  parameter int PWRUP_CYC     = 2_000_000,
  parameter int SETUP_CYC     = 2,
  parameter int EN_HIGH_CYC   = 12,
  parameter int HOLD_CYC      = 1,
  parameter int EXEC_CYC      = 2000,
  parameter int EXEC_LONG_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lcd_wr,
  input  logic [31:0] i_lcd_reg,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overrun
);

  import lcd_pkg::*;

  localparam int MAXC = (PWRUP_CYC > EXEC_LONG_CYC) ?
                        PWRUP_CYC : EXEC_LONG_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  lcd_state_e  r_state, w_next;
  lcd_cmd_t    r_slot, w_in, w_cmd;
  logic        r_slot_full;
  logic        w_slot_rd, w_bypass;
  logic        w_done, w_load;
  logic [TW-1:0] w_load_val;
  logic [1:0]  r_init_idx;
  logic        r_in_init;
  logic [7:0]  r_data;
  logic        r_rs, r_en, r_on;
  logic        r_busy, r_ovr;
  logic        w_unused_bits;

  assign w_in.rs   = i_lcd_reg[LCD_RS_BIT];
  assign w_in.data = i_lcd_reg[LCD_DATA_LSB +: 8];
  assign w_unused_bits = ^i_lcd_reg[30:9];

  lcd_timer #(
    .W       (TW),
    .RST_VAL (PWRUP_CYC - 1)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_PWRUP;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_slot_rd = 1'b0;
    w_bypass  = 1'b0;
    w_cmd     = r_slot;
    unique case (r_state)
      S_PWRUP: if (w_done) w_next = S_INIT;
      S_INIT: begin
        w_next     = S_SETUP;
        w_cmd.rs   = 1'b0;
        w_cmd.data = init_rom(r_init_idx);
      end
      S_SETUP: if (w_done) w_next = S_EN_HI;
      S_EN_HI: if (w_done) w_next = S_HOLD;
      S_HOLD:  if (w_done) w_next = S_EXEC;
      S_EXEC: begin
        if (w_done) begin
          if (r_in_init) begin
            w_next = (r_init_idx == 2'd3) ?
                     S_IDLE : S_INIT;
          end else if (r_slot_full) begin
            w_next    = S_SETUP;
            w_slot_rd = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (r_slot_full) begin
          w_next    = S_SETUP;
          w_slot_rd = 1'b1;
        end else if (i_lcd_wr) begin
          // idle write goes straight to the bus
          w_next   = S_SETUP;
          w_bypass = 1'b1;
          w_cmd    = w_in;
        end
      end
      default: w_next = S_PWRUP;
    endcase
  end

  always_comb begin
    w_load     = (w_next != r_state);
    w_load_val = '0;
    unique case (w_next)
      S_PWRUP: w_load_val = TW'(PWRUP_CYC - 1);
      S_SETUP: w_load_val = TW'(SETUP_CYC - 1);
      S_EN_HI: w_load_val = TW'(EN_HIGH_CYC - 1);
      S_HOLD:  w_load_val = TW'(HOLD_CYC - 1);
      S_EXEC: begin
        if (is_long_cmd(r_rs, r_data))
          w_load_val = TW'(EXEC_LONG_CYC - 1);
        else
          w_load_val = TW'(EXEC_CYC - 1);
      end
      default: w_load_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot      <= '0;
      r_slot_full <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      if (w_slot_rd) r_slot_full <= 1'b0;
      if (i_lcd_wr && !w_bypass) begin
        if (!r_slot_full || w_slot_rd) begin
          r_slot      <= w_in;
          r_slot_full <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data     <= '0;
      r_rs       <= 1'b0;
      r_en       <= 1'b0;
      r_on       <= 1'b0;
      r_busy     <= 1'b1;
      r_init_idx <= '0;
      r_in_init  <= 1'b1;
    end else begin
      if (w_next == S_SETUP &&
          r_state != S_SETUP) begin
        r_rs   <= w_cmd.rs;
        r_data <= w_cmd.data;
      end
      r_en   <= (w_next == S_EN_HI);
      r_busy <= (r_state != S_IDLE) | r_slot_full;
      if (i_lcd_wr) r_on <= i_lcd_reg[LCD_ON_BIT];
      if (r_state == S_EXEC && w_done &&
          r_in_init) begin
        r_init_idx <= r_init_idx + 2'd1;
        if (r_init_idx == 2'd3) r_in_init <= 1'b0;
      end
    end
  end

  assign o_lcd_data = r_data;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_en;
  assign o_lcd_on   = r_on;
  assign o_busy     = r_busy;
  assign o_overrun  = r_ovr;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl with shortened timing.
// All sampling and driving happens on the falling clock edge.
module tb_lcd_hd44780_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] reg_v = '0;
  logic [7:0]  data;
  logic        rs, rw, en, on, busy, ovr;

  int checks = 0;
  int errors = 0;

  lcd_hd44780_ctrl #(
    .PWRUP_CYC     (20),
    .SETUP_CYC     (2),
    .EN_HIGH_CYC   (3),
    .HOLD_CYC      (1),
    .EXEC_CYC      (10),
    .EXEC_LONG_CYC (40)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_lcd_wr   (wr),
    .i_lcd_reg  (reg_v),
    .o_lcd_data (data),
    .o_lcd_rs   (rs),
    .o_lcd_rw   (rw),
    .o_lcd_en   (en),
    .o_lcd_on   (on),
    .o_busy     (busy),
    .o_overrun  (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_en(output int n);
    n = 0;
    while (!en && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse(input string tag,
                       input logic [7:0] d,
                       input logic r,
                       input int gap);
    int n, w;
    wait_en(n);
    chk({tag, ".gap"}, n, gap);
    chk({tag, ".data"}, {24'h0, data}, {24'h0, d});
    chk({tag, ".rs"}, {31'h0, rs}, {31'h0, r});
    w = 0;
    while (en && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".width"}, w, 3);
  endtask

  task automatic wr_cycle(input logic [31:0] v);
    wr    = 1'b1;
    reg_v = v;
    @(negedge clk);
    wr    = 1'b0;
    reg_v = '0;
  endtask

  task automatic busy_end(input string tag);
    repeat (11) @(negedge clk);
    chk({tag, ".busy_hi"}, {31'h0, busy}, 1);
    @(negedge clk);
    chk({tag, ".busy_lo"}, {31'h0, busy}, 0);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.en", {31'h0, en}, 0);
    chk("rst.data", {24'h0, data}, 0);
    chk("rst.rs", {31'h0, rs}, 0);
    chk("rst.rw", {31'h0, rw}, 0);
    chk("rst.on", {31'h0, on}, 0);
    chk("rst.busy", {31'h0, busy}, 1);
    chk("rst.ovr", {31'h0, ovr}, 0);

    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("pwrup.busy", {31'h0, busy}, 1);
    pulse("i0", 8'h38, 1'b0, 13);
    pulse("i1", 8'h0C, 1'b0, 14);
    pulse("i2", 8'h01, 1'b0, 14);
    pulse("i3", 8'h06, 1'b0, 44);
    busy_end("init");

    repeat (3) @(negedge clk);
    wr_cycle(32'h0000_0141);
    chk("A.rs", {31'h0, rs}, 1);
    chk("A.data", {24'h0, data}, 32'h41);
    chk("A.en0", {31'h0, en}, 0);
    pulse("A", 8'h41, 1'b1, 2);
    repeat (2) @(negedge clk);
    chk("A.busy", {31'h0, busy}, 1);
    wr_cycle(32'h0000_0142);
    chk("B.ovr0", {31'h0, ovr}, 0);
    wr_cycle(32'h0000_0143);
    chk("C.ovr1", {31'h0, ovr}, 1);
    pulse("B", 8'h42, 1'b1, 9);
    busy_end("B");
    chk("B.hold", {24'h0, data}, 32'h42);
    chk("B.ovr", {31'h0, ovr}, 1);

    repeat (2) @(negedge clk);
    wr_cycle(32'h0000_0001);
    pulse("clr", 8'h01, 1'b0, 2);
    wr_cycle(32'h0000_0101);
    pulse("d01", 8'h01, 1'b1, 42);
    busy_end("d01");

    repeat (2) @(negedge clk);
    wr_cycle(32'h0000_0141);
    wait_en(n);
    chk("r.gap", n, 2);
    @(negedge clk);
    chk("r.en_hi", {31'h0, en}, 1);
    rst_n = 1'b0;
    #1;
    chk("r.en_async", {31'h0, en}, 0);
    chk("r.busy", {31'h0, busy}, 1);
    chk("r.ovr", {31'h0, ovr}, 0);
    chk("r.data", {24'h0, data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("r.pwrup", {31'h0, busy}, 1);
    pulse("r0", 8'h38, 1'b0, 13);
    wr_cycle(32'h8000_0000);
    chk("on.set", {31'h0, on}, 1);
    pulse("r1", 8'h0C, 1'b0, 13);
    pulse("r2", 8'h01, 1'b0, 14);
    pulse("r3", 8'h06, 1'b0, 44);
    pulse("pend", 8'h00, 1'b0, 14);
    chk("on.keep", {31'h0, on}, 1);
    chk("r.ovr_end", {31'h0, ovr}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
